// File: rtl/con_arb_pkg.sv
// Shared types, default widths and strobe legality helper for the datamem port-B arbiter.
package con_arb_pkg;

    localparam int NREQ_DEF   = 3;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int STRB_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Only full word, aligned half words and single bytes may be written; 0000 is a read.
    function automatic logic strobe_legal(input logic [STRB_W-1:0] we);
        logic ok;
        case (we)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0000: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/con_rr_pick.sv
// Combinational round-robin picker: first unmasked requester after last_grant wins.
module con_rr_pick
    import con_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    logic [NREQ-1:0] eligible_s;

    assign eligible_s = req & ~mask;

    // Scan offsets 1..NREQ from last_grant; the first eligible candidate wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any_grant && eligible_s[i] &&
                    ((int'(last_grant) + off == i) || (int'(last_grant) + off == i + NREQ))) begin
                    any_grant = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end else begin
                    any_grant = any_grant;
                end
            end
        end
    end

endmodule

// File: rtl/con_port_arbiter.sv
// Arbitrates protocol controllers onto datamem port B: IDLE -> ACCESS -> RESP, one transaction per 3 cycles.
module con_port_arbiter
    import con_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     con_clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [STRB_W*NREQ-1:0]   req_we,
    input  logic [ADDR_W*NREQ-1:0]   req_addr,
    input  logic [DATA_W*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]          ack,
    output logic                     err,
    output logic [DATA_W-1:0]        rdata,
    output logic [STRB_W-1:0]        con_write,
    output logic [ADDR_W-1:0]        con_addr,
    output logic [DATA_W-1:0]        con_in,
    input  logic [DATA_W-1:0]        con_out
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e         state_r, state_s;
    logic [NREQ-1:0]    grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               any_grant_s;
    logic [STRB_W-1:0]  sel_we_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;
    logic               sel_legal_s;
    logic [NREQ-1:0]    ack_next_s;

    logic [IDX_W-1:0]   last_grant_r;
    logic [IDX_W-1:0]   win_idx_r;
    logic [STRB_W-1:0]  win_we_r;
    logic               win_ill_r;
    logic [NREQ-1:0]    ack_r;
    logic               err_r;
    logic [DATA_W-1:0]  rdata_r;
    logic [STRB_W-1:0]  con_write_r;
    logic [ADDR_W-1:0]  con_addr_r;
    logic [DATA_W-1:0]  con_in_r;

    // A requester whose ack is high this cycle is masked so it cannot be granted twice in a row.
    con_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .mask       (ack_r),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s),
        .any_grant  (any_grant_s)
    );

    // One-hot mux of the winning requester's strobe, address and data.
    always_comb begin
        sel_we_s    = '0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                sel_we_s    = sel_we_s    | req_we[STRB_W*i +: STRB_W];
                sel_addr_s  = sel_addr_s  | req_addr[ADDR_W*i +: ADDR_W];
                sel_wdata_s = sel_wdata_s | req_wdata[DATA_W*i +: DATA_W];
            end else begin
                sel_we_s    = sel_we_s;
                sel_addr_s  = sel_addr_s;
                sel_wdata_s = sel_wdata_s;
            end
        end
        sel_legal_s = strobe_legal(sel_we_s);
    end

    // Decode the latched winner index into the ack vector for the RESP cycle.
    always_comb begin
        ack_next_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_r == IDX_W'(i)) begin
                ack_next_s[i] = 1'b1;
            end else begin
                ack_next_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_grant_s) begin
                    state_s = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS:  state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge con_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: con_write is loaded on the grant edge so it is live exactly during ACCESS.
    always_ff @(posedge con_clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= IDX_W'(NREQ - 1);
            win_idx_r    <= '0;
            win_we_r     <= '0;
            win_ill_r    <= 1'b0;
            ack_r        <= '0;
            err_r        <= 1'b0;
            rdata_r      <= '0;
            con_write_r  <= '0;
            con_addr_r   <= '0;
            con_in_r     <= '0;
        end else begin
            ack_r       <= '0;
            err_r       <= 1'b0;
            con_write_r <= '0;
            case (state_r)
                IDLE: begin
                    if (any_grant_s) begin
                        win_idx_r   <= grant_idx_s;
                        win_we_r    <= sel_we_s;
                        win_ill_r   <= ~sel_legal_s;
                        con_addr_r  <= sel_addr_s;
                        con_in_r    <= sel_wdata_s;
                        con_write_r <= sel_legal_s ? sel_we_s : 4'b0000;
                    end else begin
                        win_idx_r <= win_idx_r;
                    end
                end
                ACCESS: begin
                    win_idx_r <= win_idx_r;
                end
                RESP: begin
                    ack_r        <= ack_next_s;
                    err_r        <= win_ill_r;
                    last_grant_r <= win_idx_r;
                    if (!win_ill_r && (win_we_r == 4'b0000)) begin
                        rdata_r <= con_out;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                default: begin
                    win_idx_r <= win_idx_r;
                end
            endcase
        end
    end

    assign ack       = ack_r;
    assign err       = err_r;
    assign rdata     = rdata_r;
    assign con_write = con_write_r;
    assign con_addr  = con_addr_r;
    assign con_in    = con_in_r;

endmodule

// File: tb/tb_con_port_arbiter.sv
// Scoreboard bench for con_port_arbiter: a transaction-level model predicts writes and acks, a monitor compares.
module tb_con_port_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 10;
    localparam int DW   = 32;

    logic             con_clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req = '0;
    logic [4*NREQ-1:0]  req_we = '0;
    logic [AW*NREQ-1:0] req_addr = '0;
    logic [DW*NREQ-1:0] req_wdata = '0;
    logic [NREQ-1:0]  ack;
    logic             err;
    logic [DW-1:0]    rdata;
    logic [3:0]       con_write;
    logic [AW-1:0]    con_addr;
    logic [DW-1:0]    con_in;
    logic [DW-1:0]    con_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    con_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .con_clk   (con_clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .con_write (con_write),
        .con_addr  (con_addr),
        .con_in    (con_in),
        .con_out   (con_out)
    );

    always #5 con_clk = ~con_clk;

    // Datamem port B stand-in: byte-strobed write, one-cycle synchronous read.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge con_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (con_write[b]) ram[con_addr][8*b +: 8] <= con_in[8*b +: 8];
        end
        con_out <= ram[con_addr];
    end

    typedef struct {
        int         idx;
        logic       err;
        logic [31:0] rd;
        int         cyc;
    } ack_exp_t;

    typedef struct {
        logic [3:0]  we;
        logic [9:0]  a;
        logic [31:0] d;
    } cw_t;

    ack_exp_t ackq[$];
    cw_t      exp_cw[int];
    int       ack_log[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    // Reference model state
    logic        cur_v = 1'b0;
    int          cur_e, cur_idx;
    logic [3:0]  cur_we;
    logic [9:0]  cur_a;
    logic [31:0] cur_d;
    logic [31:0] m_rd = '0;
    int          m_last = NREQ - 1;
    int          m_win_e = -100;
    int          next_free = 0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
    end

    function automatic logic is_legal(input logic [3:0] we);
        return we inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    endfunction

    // Transaction-level model: grant every 3 edges round-robin, memory effect one edge after grant.
    initial begin
        ack_exp_t ae;
        cw_t      cw;
        logic     found, legal;
        int       win, c;
        forever begin
            @(posedge con_clk);
            cyc = cyc + 1;
            if (rst) begin
                cur_v = 1'b0;
                ackq.delete();
                exp_cw.delete();
                m_last = NREQ - 1;
                m_win_e = -100;
                next_free = 0;
                m_rd = '0;
            end else begin
                if (cur_v && cyc == cur_e + 1) begin
                    legal = is_legal(cur_we);
                    if (legal && cur_we != 4'h0) begin
                        for (int b = 0; b < 4; b++)
                            if (cur_we[b]) ref_mem[cur_a][8*b +: 8] = cur_d[8*b +: 8];
                    end else if (cur_we == 4'h0) begin
                        m_rd = ref_mem[cur_a];
                    end
                    ae.idx = cur_idx; ae.err = !legal; ae.rd = m_rd; ae.cyc = cur_e + 2;
                    ackq.push_back(ae);
                    cur_v = 1'b0;
                end
                if (cyc >= next_free) begin
                    found = 1'b0;
                    win = 0;
                    for (int off = 1; off <= NREQ; off++) begin
                        c = (m_last + off) % NREQ;
                        if (!found && req[c] && !(c == m_last && cyc == m_win_e + 3)) begin
                            found = 1'b1;
                            win = c;
                        end
                    end
                    if (found) begin
                        cur_v = 1'b1; cur_e = cyc; cur_idx = win;
                        cur_we = req_we[4*win +: 4];
                        cur_a  = req_addr[AW*win +: AW];
                        cur_d  = req_wdata[DW*win +: DW];
                        cw.we = is_legal(cur_we) ? cur_we : 4'h0;
                        cw.a = cur_a; cw.d = cur_d;
                        exp_cw[cyc] = cw;
                        m_last = win; m_win_e = cyc; next_free = cyc + 3;
                    end
                end
            end
        end
    end

    // Monitor: compares port-B strobes every cycle and pops an expectation on every ack.
    initial begin
        cw_t      cw;
        ack_exp_t e;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge con_clk);
            if (!rst) begin
                if (exp_cw.exists(cyc)) cw = exp_cw[cyc];
                else begin cw.we = 4'h0; cw.a = '0; cw.d = '0; end
                n_cmp++;
                if (con_write !== cw.we || (cw.we != 4'h0 && (con_addr !== cw.a || con_in !== cw.d))) begin
                    n_fail++;
                    $display("FAIL port_b cyc=%0d: got we=%b addr=%h in=%h expected we=%b addr=%h in=%h",
                             cyc, con_write, con_addr, con_in, cw.we, cw.a, cw.d);
                end
                if (ackq.size() > 0 && ackq[0].cyc < cyc) begin
                    e = ackq.pop_front();
                    n_cmp++; n_fail++;
                    $display("FAIL missing_ack cyc=%0d: got none expected ack idx %0d at cyc %0d", cyc, e.idx, e.cyc);
                end
                if (ack !== '0) begin
                    for (int k = 0; k < NREQ; k++) if (ack[k]) ack_log.push_back(k);
                    n_cmp++;
                    if (ackq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_ack cyc=%0d: got ack=%b expected none", cyc, ack);
                    end else begin
                        e = ackq.pop_front();
                        oh = NREQ'(1) << e.idx;
                        if (ack !== oh || err !== e.err || rdata !== e.rd || cyc != e.cyc) begin
                            n_fail++;
                            $display("FAIL ack cyc=%0d: got ack=%b err=%b rdata=%h expected ack=%b err=%b rdata=%h at cyc %0d",
                                     cyc, ack, err, rdata, oh, e.err, e.rd, e.cyc);
                        end
                    end
                end else if (err !== 1'b0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL err_alone cyc=%0d: got err=%b expected 0", cyc, err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request and hold it until its ack (bounded), then drop it.
    task automatic issue(input int i, input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
        logic got;
        @(negedge con_clk);
        req_we[4*i +: 4]     = we;
        req_addr[AW*i +: AW] = a;
        req_wdata[DW*i +: DW] = d;
        req[i] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge con_clk);
            if (ack[i]) got = 1'b1;
        end
        req[i] = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout req%0d: got no ack expected ack within 60 cycles", i);
        end
    endtask

    task automatic requester(input int i);
        logic [3:0] we;
        int r;
        repeat (15) begin
            repeat ($urandom_range(0, 3)) @(negedge con_clk);
            r = $urandom_range(0, 9);
            if (r < 3)       we = 4'h0;
            else if (r == 3) we = 4'hF;
            else             we = 4'($urandom_range(0, 15));
            issue(i, we, 10'h100 + 10'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge con_clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_con_write", 32'(con_write), 32'h0);
        check("rst_con_addr", 32'(con_addr), 32'h0);
        check("rst_con_in", con_in, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        #2 rst = 1'b0;

        issue(0, 4'hF, 10'h010, 32'hDEADBEEF);
        check("wr_err", 32'(err), 32'h0);
        issue(1, 4'h0, 10'h010, 32'h0);
        check("rd_deadbeef", rdata, 32'hDEADBEEF);
        issue(0, 4'hF, 10'h020, 32'hCAFEF00D);
        issue(2, 4'h5, 10'h020, 32'h55555555);
        check("illegal_err", 32'(err), 32'h1);
        check("illegal_rdata_hold", rdata, 32'hDEADBEEF);
        issue(1, 4'h0, 10'h020, 32'h0);
        check("illegal_no_write", rdata, 32'hCAFEF00D);
        issue(0, 4'hF, 10'h030, 32'h11223344);
        issue(2, 4'h4, 10'h030, 32'h00AA0000);
        issue(1, 4'h0, 10'h030, 32'h0);
        check("byte_write", rdata, 32'h11AA3344);

        // Reset while in ACCESS: the write must be suppressed immediately.
        @(negedge con_clk);
        req_we[7:4] = 4'hF; req_addr[19:10] = 10'h050; req_wdata[63:32] = 32'h12345678;
        req[1] = 1'b1;
        @(negedge con_clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_con_write", 32'(con_write), 32'h0);
        check("midrst_ack", 32'(ack), 32'h0);
        req = '0;
        repeat (2) @(negedge con_clk);
        check("midrst_no_mem_write", ram[10'h050], 32'h0);
        #2 rst = 1'b0;

        // Sustained contention right after reset.
        @(negedge con_clk);
        ack_log.delete();
        req_we = '0;
        req_addr = {10'h030, 10'h020, 10'h010};
        req = 3'b111;
        repeat (12) @(negedge con_clk);
        req = '0;
        repeat (5) @(negedge con_clk);
        check("contention_count", 32'(ack_log.size()), 32'd4);
        if (ack_log.size() >= 4) begin
            check("contention_0", 32'(ack_log[0]), 32'd0);
            check("contention_1", 32'(ack_log[1]), 32'd1);
            check("contention_2", 32'(ack_log[2]), 32'd2);
            check("contention_3", 32'(ack_log[3]), 32'd0);
        end

        fork
            requester(0);
            requester(1);
            requester(2);
        join

        repeat (10) @(negedge con_clk);
        check("scoreboard_drained", 32'(ackq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
